// File: rtl/alu_test_driver_pkg.sv
// Shared opcode encoding, FSM state codes, default LFSR constants and the
// golden ALU model used by alu_test_driver.
package alu_test_pkg;

  localparam int ALU_MAX_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;

  // Computed at the widest supported width; callers truncate to their width,
  // which yields the required modulo-2^W add/sub.
  function automatic logic [ALU_MAX_W-1:0] alu_expect(
    input logic [ALU_MAX_W-1:0] a,
    input logic [ALU_MAX_W-1:0] b,
    input alu_op_e              op
  );
    logic [ALU_MAX_W-1:0] y;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      default: y = a | b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/alu_test_driver_if.sv
// Operand/opcode/result bundle between alu_test_driver (master) and the
// combinational ALU under test (slave).
interface alu_test_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic [1:0]       dut_opcode;
  logic [WIDTH-1:0] dut_y;
  logic             dut_zero;

  modport master (
    output dut_a,
    output dut_b,
    output dut_opcode,
    input  dut_y,
    input  dut_zero
  );

  modport slave (
    input  dut_a,
    input  dut_b,
    input  dut_opcode,
    output dut_y,
    output dut_zero
  );
endinterface

// File: rtl/alu_test_driver_galois_lfsr.sv
// Left-shifting Galois LFSR; data_in is folded in on each step so the same
// block serves as stimulus generator (data_in=0) and as MISR.
module galois_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = {state_q[WIDTH-2:0], 1'b0}
              ^ (state_q[WIDTH-1] ? TAPS : '0)
              ^ data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/alu_test_driver.sv
// Stimulus/response engine for the 4-op ALU: LFSR operands, golden-model
// checking, mismatch counting and MISR signature. Optional feature macro:
// ALU_DRV_CORNER_VECTORS_EN (8 fixed corner vectors before the LFSR vectors).
module alu_test_driver
  import alu_test_pkg::*;
#(
  parameter int                 WIDTH       = 8,
  parameter int                 NUM_VECTORS = 256,
  parameter logic [2*WIDTH-1:0] LFSR_SEED   = DEF_LFSR_SEED,
  parameter logic [2*WIDTH-1:0] LFSR_TAPS   = DEF_LFSR_TAPS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  alu_test_driver_if.master    alu,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          mismatch_count,
  output logic [15:0]          first_fail_idx,
  output logic [2*WIDTH-1:0]   signature
);

`ifdef ALU_DRV_CORNER_VECTORS_EN
  localparam int NUM_CORNER = 8;
`else
  localparam int NUM_CORNER = 0;
`endif
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS + NUM_CORNER - 1);

  state_t state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] mm_q, mm_d;
  logic [15:0] ff_q, ff_d;

  logic               lfsr_load;
  logic               lfsr_step;
  logic               misr_load;
  logic               misr_step;
  logic [2*WIDTH-1:0] lfsr_state;
  logic [2*WIDTH-1:0] misr_state;
  logic [WIDTH-1:0]   exp_y;
  logic               exp_zero;
  logic               vec_fail;

  galois_lfsr #(
    .WIDTH (2*WIDTH),
    .TAPS  (LFSR_TAPS)
  ) u_stim_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (LFSR_SEED),
    .step     (lfsr_step),
    .data_in  ('0),
    .state    (lfsr_state)
  );

  galois_lfsr #(
    .WIDTH (2*WIDTH),
    .TAPS  (LFSR_TAPS)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (misr_load),
    .load_val ('0),
    .step     (misr_step),
    .data_in  ({{(WIDTH-1){1'b0}}, alu.dut_zero, alu.dut_y}),
    .state    (misr_state)
  );

  // Operands come straight from flops: the LFSR state (or, in the corner
  // phase, a pattern decoded from idx), and the opcode is idx's low bits.
`ifdef ALU_DRV_CORNER_VECTORS_EN
  logic in_corner;
  assign in_corner     = (idx_q < 16'(NUM_CORNER));
  assign alu.dut_a     = in_corner ? {WIDTH{idx_q[2]}} : lfsr_state[2*WIDTH-1:WIDTH];
  assign alu.dut_b     = in_corner ? {WIDTH{idx_q[2]}} : lfsr_state[WIDTH-1:0];
`else
  assign alu.dut_a     = lfsr_state[2*WIDTH-1:WIDTH];
  assign alu.dut_b     = lfsr_state[WIDTH-1:0];
`endif
  assign alu.dut_opcode = idx_q[1:0];

  assign exp_y    = WIDTH'(alu_expect(ALU_MAX_W'(alu.dut_a), ALU_MAX_W'(alu.dut_b),
                                      alu_op_e'(alu.dut_opcode)));
  assign exp_zero = (exp_y == '0);
  assign vec_fail = (alu.dut_y != exp_y) || (alu.dut_zero != exp_zero);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mm_d      = mm_q;
    ff_d      = ff_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    misr_load = 1'b0;
    misr_step = 1'b0;
    case (state_q)
      ST_RUN: begin
        misr_step = 1'b1;
        if (vec_fail) begin
          if (mm_q != 16'hFFFF) mm_d = mm_q + 16'd1;
          if (ff_q == 16'hFFFF) ff_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 16'd1;
`ifdef ALU_DRV_CORNER_VECTORS_EN
          // LFSR holds at the seed until the first LFSR vector has been used.
          lfsr_step = (idx_q >= 16'(NUM_CORNER));
`else
          lfsr_step = 1'b1;
`endif
        end
      end
      default: begin
        if (start) begin
          state_d   = ST_RUN;
          idx_d     = '0;
          mm_d      = '0;
          ff_d      = 16'hFFFF;
          lfsr_load = 1'b1;
          misr_load = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mm_q    <= '0;
      ff_q    <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
    end
  end

  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (mm_q == 16'd0);
  assign mismatch_count = mm_q;
  assign first_fail_idx = ff_q;
  assign signature      = misr_state;

endmodule

// File: tb/tb_alu_test_driver.sv
// Bench for alu_test_driver: bench-side ALU with clean/stuck/trojan modes,
// a vector + signature model, and a per-cycle compare of the driven vectors.
`timescale 1ns/1ps
module tb_alu_test_driver;

  localparam int W  = 8;
  localparam int NV = 256;
`ifdef ALU_DRV_CORNER_VECTORS_EN
  localparam int NC = 8;
`else
  localparam int NC = 0;
`endif
  localparam int NT = NV + NC;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] mismatch_count, first_fail_idx, signature;
  int          fault_mode = 0;
  int          checks     = 0;
  int          failures   = 0;

  logic [7:0]  vec_a  [NT];
  logic [7:0]  vec_b  [NT];
  logic [1:0]  vec_op [NT];
  logic [8:0]  alu_resp;

  alu_test_driver_if #(.WIDTH(W)) alu ();

  alu_test_driver #(
    .WIDTH       (W),
    .NUM_VECTORS (NV),
    .LFSR_SEED   (SEED),
    .LFSR_TAPS   (TAPS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .alu            (alu),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .first_fail_idx (first_fail_idx),
    .signature      (signature)
  );

  always #5 clk = ~clk;

  // fault 0 = clean, 1 = outputs stuck at 0, 2 = y[0] flipped on SUB with a==b
  function automatic logic [8:0] aluRef(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op, input int fault);
    logic [7:0] y;
    logic       z;
    case (op)
      2'd0:    y = a + b;
      2'd1:    y = a - b;
      2'd2:    y = a & b;
      default: y = a | b;
    endcase
    z = (y == 8'd0);
    if (fault == 1) begin
      y = 8'd0;
      z = 1'b0;
    end else if (fault == 2 && a == b && op == 2'd1) begin
      y[0] = ~y[0];
    end
    return {z, y};
  endfunction

  function automatic logic [15:0] galoisNext(input logic [15:0] s, input logic [15:0] din);
    return (s << 1) ^ (s[15] ? TAPS : 16'h0000) ^ din;
  endfunction

  always_comb begin
    alu_resp     = aluRef(alu.dut_a, alu.dut_b, alu.dut_opcode, fault_mode);
    alu.dut_y    = alu_resp[7:0];
    alu.dut_zero = alu_resp[8];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic buildVectors();
    logic [15:0] l;
    l = SEED;
    for (int i = 0; i < NT; i++) begin
      if (i < NC) begin
        vec_a[i] = (i >= 4) ? 8'hFF : 8'h00;
        vec_b[i] = vec_a[i];
      end else begin
        vec_a[i] = l[15:8];
        vec_b[i] = l[7:0];
        l = galoisNext(l, 16'h0000);
      end
      vec_op[i] = 2'(i % 4);
    end
  endtask

  task automatic predict(input int fault, output int mm, output logic [15:0] ff,
                         output logic [15:0] sig);
    logic [8:0] got, good;
    mm  = 0;
    ff  = 16'hFFFF;
    sig = 16'h0000;
    for (int i = 0; i < NT; i++) begin
      got  = aluRef(vec_a[i], vec_b[i], vec_op[i], fault);
      good = aluRef(vec_a[i], vec_b[i], vec_op[i], 0);
      if (got != good) begin
        mm++;
        if (ff == 16'hFFFF) ff = 16'(i);
      end
      sig = galoisNext(sig, {7'b0, got});
    end
  endtask

  // Every busy cycle the driven vector must be the next one in the model list.
  int   vi        = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (!busy_prev) vi = 0;
      if (vi < NT) begin
        checkOutput("drive_a",  alu.dut_a,      vec_a[vi]);
        checkOutput("drive_b",  alu.dut_b,      vec_b[vi]);
        checkOutput("drive_op", alu.dut_opcode, vec_op[vi]);
      end else begin
        checkOutput("busy_overrun_idx", vi, NT - 1);
      end
      vi++;
    end
    busy_prev = (busy === 1'b1);
  end

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int bc);
    bc = 0;
    for (int c = 0; c < NT + 20 && done !== 1'b1; c++) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
    end
    checkOutput("done_timeout", done, 1);
  endtask

  task automatic checkRun(input int fault, input int bc);
    int          mm;
    logic [15:0] ff, sig;
    predict(fault, mm, ff, sig);
    checkOutput("busy_cycles",    bc, NT);
    checkOutput("done",           done, 1);
    checkOutput("busy_after",     busy, 0);
    checkOutput("pass",           pass, (mm == 0));
    checkOutput("mismatch_count", mismatch_count, mm);
    checkOutput("first_fail_idx", first_fail_idx, ff);
    checkOutput("signature",      signature, sig);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          bc;
    int          mm;
    logic [15:0] ff, clean_sig, sig;

    buildVectors();
    predict(0, mm, ff, clean_sig);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_mm",   mismatch_count, 0);
    checkOutput("rst_sig",  signature, 0);
    checkOutput("rst_ff",   first_fail_idx, 16'hFFFF);
    checkOutput("rst_a",    alu.dut_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] clean run 1");
    applyStimulus();
`ifdef ALU_DRV_CORNER_VECTORS_EN
    checkOutput("first_a",  alu.dut_a, 8'h00);
    checkOutput("first_b",  alu.dut_b, 8'h00);
    checkOutput("first_op", alu.dut_opcode, 2'd0);
    checkOutput("first_y",  alu.dut_y, 8'h00);
    @(negedge clk);
    checkOutput("sig_after_1", signature, 16'h0100);
    checkOutput("second_op",   alu.dut_opcode, 2'd1);
    @(negedge clk);
    checkOutput("sig_after_2", signature, 16'h0300);
`else
    checkOutput("first_a",  alu.dut_a, 8'hAC);
    checkOutput("first_b",  alu.dut_b, 8'hE1);
    checkOutput("first_op", alu.dut_opcode, 2'd0);
    checkOutput("first_y",  alu.dut_y, 8'h8D);
    checkOutput("first_z",  alu.dut_zero, 1'b0);
    @(negedge clk);
    checkOutput("sig_after_1", signature, 16'h008D);
    checkOutput("second_a",    alu.dut_a, 8'hED);
    checkOutput("second_b",    alu.dut_b, 8'hC2);
    checkOutput("second_op",   alu.dut_opcode, 2'd1);
    @(negedge clk);
    checkOutput("sig_after_2", signature, 16'h0131);
`endif
    waitDone(bc);
    checkRun(0, bc + 2);
    checkOutput("clean_pass_literal", pass, 1);
    checkOutput("clean_ff_literal",   first_fail_idx, 16'hFFFF);

    $display("[TB] clean run 2");
    applyStimulus();
    waitDone(bc);
    checkRun(0, bc);
    checkOutput("repeat_signature", signature, clean_sig);

    $display("[TB] stuck-at-zero ALU");
    fault_mode = 1;
    applyStimulus();
    waitDone(bc);
    checkRun(1, bc);
    checkOutput("stuck_mm_literal", mismatch_count, NT);
    checkOutput("stuck_ff_literal", first_fail_idx, 0);

    $display("[TB] trojan ALU");
    fault_mode = 2;
    applyStimulus();
    waitDone(bc);
    checkRun(2, bc);
    predict(2, mm, ff, sig);
    if (mm > 0) checkOutput("trojan_sig_differs", (signature != clean_sig), 1);

    $display("[TB] control: ignored start and mid-run reset");
    fault_mode = 0;
    applyStimulus();
    repeat (50) @(negedge clk);
    applyStimulus();
    checkOutput("start_ignored_busy", busy, 1);
    repeat (48) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_mm",   mismatch_count, 0);
    checkOutput("abort_ff",   first_fail_idx, 16'hFFFF);
    checkOutput("abort_sig",  signature, 0);
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", done, 0);
    applyStimulus();
    waitDone(bc);
    checkRun(0, bc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
